// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown sequencer and its bench.
package countdown_pkg;

  localparam int CD_WIDTH = 4;
  localparam int CD_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HALVE = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

  // One queued command at the default counter width.
  typedef struct packed {
    logic                halve;
    logic [CD_WIDTH-1:0] value;
  } cmd_t;

endpackage

// File: rtl/countdown_sequencer_if.sv
// Command handshake bundle: producer offers value/halve, sequencer answers ready.
interface countdown_sequencer_if #(
  parameter int WIDTH = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_value;
  logic             cmd_halve;

  modport master (
    output cmd_valid,
    output cmd_value,
    output cmd_halve,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_value,
    input  cmd_halve,
    output cmd_ready
  );

endinterface

// File: rtl/countdown_sequencer_cmd_fifo.sv
// Small synchronous command FIFO with flush; head is read combinationally.
module cmd_fifo #(
  parameter int EW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [EW-1:0]            din,
  input  logic                     pop,
  output logic [EW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, no reset needed: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Command front-end for a down counter: queues countdown values, loads each one,
// optionally halves it, waits for the zero flag and pulses done.
// Optional feature: define COUNTDOWN_SEQ_HALVE_EN to store and honour cmd_halve.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH,
  parameter int DEPTH = CD_DEPTH
) (
  input  logic                   clk,
  input  logic                   nrst,
  countdown_sequencer_if.slave   cmd,
  input  logic                   abort,
  input  logic                   zero,
  output logic                   load,
  output logic [WIDTH-1:0]       count_in,
  output logic                   divide_by_2,
  output logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending
);

`ifdef COUNTDOWN_SEQ_HALVE_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  state_e           state_q, state_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] count_in_q, count_in_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             push, pop, full, empty;
  logic [EW-1:0]    fifo_din, fifo_dout;
  logic [WIDTH-1:0] head_value;

  // Abort closes the port for the cycle so a same-cycle offer is dropped.
  assign cmd.cmd_ready = !full && !abort;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;

`ifdef COUNTDOWN_SEQ_HALVE_EN
  logic halve_q, halve_d, head_halve;
  logic div_q, div_d;
  assign fifo_din    = {cmd.cmd_halve, cmd.cmd_value};
  assign head_value  = fifo_dout[WIDTH-1:0];
  assign head_halve  = fifo_dout[WIDTH];
  assign divide_by_2 = div_q;
`else
  logic unused_halve;
  assign unused_halve = cmd.cmd_halve;
  assign fifo_din     = cmd.cmd_value;
  assign head_value   = fifo_dout;
  assign divide_by_2  = 1'b0;
`endif

  cmd_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .flush (abort),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  // Next state, pop request and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    count_in_d = count_in_q;
`ifdef COUNTDOWN_SEQ_HALVE_EN
    halve_d    = halve_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_d    = LOAD;
          count_in_d = head_value;
`ifdef COUNTDOWN_SEQ_HALVE_EN
          halve_d    = head_halve;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
`ifdef COUNTDOWN_SEQ_HALVE_EN
        state_d = halve_q ? HALVE : RUN;
`else
        state_d = RUN;
`endif
      end
      HALVE:   state_d = RUN;
      // The zero flag is only trusted here: during LOAD/HALVE it still shows the old count.
      RUN:     if (zero) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      pop        = 1'b0;
      count_in_d = count_in_q;
    end
    load_d = (state_d == LOAD);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
`ifdef COUNTDOWN_SEQ_HALVE_EN
    div_d  = (state_d == HALVE);
`endif
  end

  // State and output registers; outputs follow the state being entered.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      count_in_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      count_in_q <= count_in_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

`ifdef COUNTDOWN_SEQ_HALVE_EN
  // Halve flag of the current command and the one-cycle halve strobe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      halve_q <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      halve_q <= halve_d;
      div_q   <= div_d;
    end
  end
`endif

  assign load     = load_q;
  assign count_in = count_in_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit down counter.
module tb_countdown_sequencer;
  import countdown_pkg::*;

  logic       clk = 1'b0;
  logic       nrst;
  logic       abort;
  logic       zero;
  logic       load;
  logic [3:0] count_in;
  logic       divide_by_2;
  logic       done;
  logic       busy;
  logic [2:0] pending;
  logic [3:0] cnt;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  countdown_sequencer_if #(.WIDTH(4)) cmd_if ();

  countdown_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .cmd         (cmd_if),
    .abort       (abort),
    .zero        (zero),
    .load        (load),
    .count_in    (count_in),
    .divide_by_2 (divide_by_2),
    .done        (done),
    .busy        (busy),
    .pending     (pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural counter: load > halve > decrement-if-nonzero.
  always @(posedge clk or negedge nrst) begin
    if (!nrst)            cnt <= 4'd0;
    else if (load)        cnt <= count_in;
    else if (divide_by_2) cnt <= cnt >> 1;
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
  end
  assign zero = (cnt == 4'd0);

  function automatic cmd_t mk(input logic [3:0] v, input logic h);
    cmd_t c;
    c.value = v;
    c.halve = h;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input cmd_t c);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_value = c.value;
    cmd_if.cmd_halve = c.halve;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Ticks until done is seen; n = ticks taken, or -1 if the bound expires.
  task automatic run_until_done(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({load, count_in, divide_by_2, done, busy, pending} !== 11'd0) begin n_bad++; $display("FAIL por_outputs got=%b exp=0", {load, count_in, divide_by_2, done, busy, pending}); end
    n_cmp++; if (cmd_if.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL por_ready got=%b exp=1", cmd_if.cmd_ready); end
    nrst = 1'b1;
    tick();
    // Reset in the middle of a countdown with one command still queued.
    push(mk(4'd9, 1'b0));
    push(mk(4'd4, 1'b0));
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1 || count_in !== 4'd9 || pending !== 3'd1) begin n_bad++; $display("FAIL midrun_pre got busy=%b cin=%0d pend=%0d exp 1/9/1", busy, count_in, pending); end
    #2 nrst = 1'b0;
    #1;
    n_cmp++; if ({load, count_in, divide_by_2, done, busy, pending} !== 11'd0) begin n_bad++; $display("FAIL async_reset got=%b exp=0", {load, count_in, divide_by_2, done, busy, pending}); end
    tick();
    nrst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0 || load !== 1'b0 || pending !== 3'd0) begin n_bad++; $display("FAIL post_reset_idle got busy=%b load=%b pend=%0d exp 0/0/0", busy, load, pending); end
  endtask

  task automatic test_single();
    int n;
    push(mk(4'd5, 1'b0));
    n_cmp++; if (pending !== 3'd1 || busy !== 1'b0 || load !== 1'b0) begin n_bad++; $display("FAIL t5_queued got pend=%0d busy=%b load=%b exp 1/0/0", pending, busy, load); end
    tick();
    n_cmp++; if (load !== 1'b1 || count_in !== 4'd5 || busy !== 1'b1 || pending !== 3'd0) begin n_bad++; $display("FAIL t5_load got load=%b cin=%0d busy=%b pend=%0d exp 1/5/1/0", load, count_in, busy, pending); end
    tick();
    n_cmp++; if (load !== 1'b0 || divide_by_2 !== 1'b0) begin n_bad++; $display("FAIL t5_run got load=%b div=%b exp 0/0", load, divide_by_2); end
    run_until_done(30, n);
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL t5_done_lat got=%0d exp=6", n); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL t5_after got done=%b busy=%b exp 0/0", done, busy); end
  endtask

  task automatic test_zero();
    int n;
    push(mk(4'd0, 1'b0));
    tick();
    n_cmp++; if (load !== 1'b1 || count_in !== 4'd0) begin n_bad++; $display("FAIL t0_load got load=%b cin=%0d exp 1/0", load, count_in); end
    tick();
    run_until_done(10, n);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL t0_done_lat got=%0d exp=1", n); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t0_busy_in_done got=%b exp=1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL t0_after got busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_back_to_back();
    int c0, k;
    int done_k[$];
    int load_k[$];
    int load_v[$];
    int exp_done[5] = '{10, 16, 21, 25, 33};
    int exp_load[4] = '{11, 17, 22, 26};
    int exp_val[4]  = '{3, 2, 1, 5};
    push(mk(4'd7, 1'b0));
    c0 = cyc;
    push(mk(4'd3, 1'b0));
    n_cmp++; if (load !== 1'b1 || count_in !== 4'd7 || pending !== 3'd1) begin n_bad++; $display("FAIL b2b_first got load=%b cin=%0d pend=%0d exp 1/7/1", load, count_in, pending); end
    push(mk(4'd2, 1'b0));
    push(mk(4'd1, 1'b0));
    push(mk(4'd5, 1'b0));
    n_cmp++; if (pending !== 3'd4 || cmd_if.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full got pend=%0d rdy=%b exp 4/0", pending, cmd_if.cmd_ready); end
    push(mk(4'd9, 1'b0));
    n_cmp++; if (pending !== 3'd4) begin n_bad++; $display("FAIL b2b_drop got pend=%0d exp 4", pending); end
    for (int i = 0; i < 40; i++) begin
      tick();
      k = cyc - c0;
      if (done === 1'b1) done_k.push_back(k);
      if (load === 1'b1) begin
        load_k.push_back(k);
        load_v.push_back(int'(count_in));
      end
    end
    n_cmp++; if (done_k.size() !== 5 || load_k.size() !== 4) begin n_bad++; $display("FAIL b2b_counts got done=%0d loads=%0d exp 5/4", done_k.size(), load_k.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (i >= done_k.size() || done_k[i] !== exp_done[i]) begin n_bad++; $display("FAIL b2b_done%0d got=%0d exp=%0d", i, (i < done_k.size()) ? done_k[i] : -1, exp_done[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (i >= load_k.size() || load_k[i] !== exp_load[i] || load_v[i] !== exp_val[i]) begin n_bad++; $display("FAIL b2b_load%0d got cyc=%0d val=%0d exp %0d/%0d", i, (i < load_k.size()) ? load_k[i] : -1, (i < load_v.size()) ? load_v[i] : -1, exp_load[i], exp_val[i]); end
    end
    n_cmp++; if (busy !== 1'b0 || pending !== 3'd0) begin n_bad++; $display("FAIL b2b_end got busy=%b pend=%0d exp 0/0", busy, pending); end
  endtask

  task automatic test_abort();
    int n_done = 0;
    int n_load = 0;
    int n_busy = 0;
    push(mk(4'd6, 1'b0));
    push(mk(4'd4, 1'b0));
    push(mk(4'd8, 1'b0));
    tick();
    n_cmp++; if (pending !== 3'd2 || busy !== 1'b1) begin n_bad++; $display("FAIL ab_pre got pend=%0d busy=%b exp 2/1", pending, busy); end
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_value = 4'd3;
    #1;
    n_cmp++; if (cmd_if.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ab_ready got=%b exp=0", cmd_if.cmd_ready); end
    tick();
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    n_cmp++; if (pending !== 3'd0 || busy !== 1'b0 || load !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL ab_flush got pend=%0d busy=%b load=%b done=%b exp 0/0/0/0", pending, busy, load, done); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) n_done++;
      if (load === 1'b1) n_load++;
      if (busy === 1'b1) n_busy++;
    end
    n_cmp++; if (n_done !== 0 || n_load !== 0 || n_busy !== 0 || pending !== 3'd0) begin n_bad++; $display("FAIL ab_quiet got done=%0d load=%0d busy=%0d pend=%0d exp 0/0/0/0", n_done, n_load, n_busy, pending); end
  endtask

  task automatic test_halve();
    int n;
    push(mk(4'd12, 1'b1));
    tick();
    n_cmp++; if (load !== 1'b1 || count_in !== 4'd12 || divide_by_2 !== 1'b0) begin n_bad++; $display("FAIL hv_load got load=%b cin=%0d div=%b exp 1/12/0", load, count_in, divide_by_2); end
    tick();
`ifdef COUNTDOWN_SEQ_HALVE_EN
    n_cmp++; if (load !== 1'b0 || divide_by_2 !== 1'b1) begin n_bad++; $display("FAIL hv_div got load=%b div=%b exp 0/1", load, divide_by_2); end
    tick();
    n_cmp++; if (divide_by_2 !== 1'b0 || cnt !== 4'd6) begin n_bad++; $display("FAIL hv_halved got div=%b cnt=%0d exp 0/6", divide_by_2, cnt); end
    run_until_done(30, n);
    n_cmp++; if (n !== 7) begin n_bad++; $display("FAIL hv_done_lat got=%0d exp=7", n); end
`else
    n_cmp++; if (load !== 1'b0 || divide_by_2 !== 1'b0) begin n_bad++; $display("FAIL hv_ignored got load=%b div=%b exp 0/0", load, divide_by_2); end
    run_until_done(30, n);
    n_cmp++; if (n !== 13) begin n_bad++; $display("FAIL hv_done_lat got=%0d exp=13", n); end
`endif
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hv_after got busy=%b exp 0", busy); end
  endtask

  initial begin
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_value = 4'd0;
    cmd_if.cmd_halve = 1'b0;
    test_reset();
    test_single();
    test_zero();
    test_back_to_back();
    test_abort();
    test_halve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
